// File: rtl/popcount_frame_accum.sv
// Two-stage frame popcount accumulator: stage 1 registers the per-word set-bit
// count, stage 2 sums counts and words per frame (saturating) into a result register.
// Optional build macro POPCNT_MAX_EN adds per-frame maximum word count on out_max.
module popcount_frame_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_total,
  output logic [15:0] out_words,
  output logic        out_sat
`ifdef POPCNT_MAX_EN
  ,
  output logic [5:0]  out_max
`endif
);

  function automatic logic [5:0] popcount32(input logic [31:0] d);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, d[i]};
    end
    return c;
  endfunction

  logic        s1_valid;
  logic [5:0]  s1_cnt;
  logic        s1_last;

  logic [15:0] acc_total;
  logic [15:0] acc_words;
  logic        acc_sat;

  logic        s1_hold;
  logic        accept;
  logic        s2_take;
  logic        complete;
  logic        xfer;

  logic [16:0] sum_total;
  logic [16:0] sum_words;
  logic [15:0] total_next;
  logic [15:0] words_next;
  logic        sat_next;

  // A last beat may only leave stage 1 when the result register can take it.
  assign s1_hold  = s1_valid & s1_last & out_valid & ~out_ready;
  assign in_ready = ~s1_hold;
  assign accept   = in_valid & in_ready;
  assign s2_take  = s1_valid & ~s1_hold;
  assign complete = s2_take & s1_last;
  assign xfer     = out_valid & out_ready;

  assign sum_total  = {1'b0, acc_total} + {11'd0, s1_cnt};
  assign sum_words  = {1'b0, acc_words} + 17'd1;
  assign total_next = sum_total[16] ? 16'hFFFF : sum_total[15:0];
  assign words_next = sum_words[16] ? 16'hFFFF : sum_words[15:0];
  assign sat_next   = acc_sat | sum_total[16] | sum_words[16];

`ifdef POPCNT_MAX_EN
  logic [5:0] acc_max;
  logic [5:0] max_next;

  assign max_next = (s1_cnt > acc_max) ? s1_cnt : acc_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_max <= 6'd0;
      out_max <= 6'd0;
    end else begin
      if (s2_take) begin
        acc_max <= s1_last ? 6'd0 : max_next;
      end
      if (complete) begin
        out_max <= max_next;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cnt    <= 6'd0;
      s1_last   <= 1'b0;
      acc_total <= 16'd0;
      acc_words <= 16'd0;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_total <= 16'd0;
      out_words <= 16'd0;
      out_sat   <= 1'b0;
    end else begin
      if (!s1_hold) begin
        s1_valid <= accept;
        if (accept) begin
          s1_cnt  <= popcount32(in_data);
          s1_last <= in_last;
        end
      end

      if (s2_take) begin
        if (s1_last) begin
          acc_total <= 16'd0;
          acc_words <= 16'd0;
          acc_sat   <= 1'b0;
        end else begin
          acc_total <= total_next;
          acc_words <= words_next;
          acc_sat   <= sat_next;
        end
      end

      // Completion wins over transfer: a simultaneous pair keeps the register full.
      if (complete) begin
        out_valid <= 1'b1;
        out_total <= total_next;
        out_words <= words_next;
        out_sat   <= sat_next;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed self-checking bench for popcount_frame_accum; expected values are hand-computed.
// Builds with or without POPCNT_MAX_EN.
module tb_popcount_frame_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_total;
  logic [15:0] out_words;
  logic        out_sat;
`ifdef POPCNT_MAX_EN
  logic [5:0]  out_max;
`endif

  int n_checks;
  int n_fail;

  popcount_frame_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_words (out_words),
    .out_sat   (out_sat)
`ifdef POPCNT_MAX_EN
    ,
    .out_max   (out_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat was accepted with out_ready=1:
  // result must appear exactly one edge later and drain the edge after.
  task automatic expect_result(input string tag, input logic [15:0] tot, input logic [15:0] wds,
                               input logic sat, input logic [5:0] mx);
    check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_total"}, {16'd0, out_total}, {16'd0, tot});
    check({tag, "_words"}, {16'd0, out_words}, {16'd0, wds});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, sat});
`ifdef POPCNT_MAX_EN
    check({tag, "_max"}, {26'd0, out_max}, {26'd0, mx});
`else
    if (mx > 6'd32) $display("note: bad max argument in %s", tag);
`endif
    @(posedge clk);
    #1;
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_total", {16'd0, out_total}, 32'd0);
    check("rst_words", {16'd0, out_words}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);

    // Two-word frame: 32 + 4
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_000F, 1'b1);
    expect_result("f36", 16'd36, 16'd2, 1'b0, 6'd32);

    send(32'h8000_0001, 1'b1);
    expect_result("one2", 16'd2, 16'd1, 1'b0, 6'd2);
    send(32'h0000_0000, 1'b1);
    expect_result("zero", 16'd0, 16'd1, 1'b0, 6'd0);

    // Mixed three-word frame: 16 + 1 + 16
    send(32'h0F0F_0F0F, 1'b0);
    send(32'h0000_0001, 1'b0);
    send(32'hAAAA_AAAA, 1'b1);
    expect_result("mix", 16'd33, 16'd3, 1'b0, 6'd16);

    // Back-pressure: two single-word frames with out_ready low
    out_ready = 1'b0;
    send(32'h0000_00FF, 1'b1);
    send(32'h0000_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_total", {16'd0, out_total}, 32'd8);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp2_valid", {31'd0, out_valid}, 32'd1);
    check("bp2_total", {16'd0, out_total}, 32'd16);
    check("bp2_words", {16'd0, out_words}, 32'd1);
    check("bp2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Saturation: 2050 words of all-ones -> total clips, words do not
    for (int i = 0; i < 2049; i++) send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    expect_result("sat", 16'hFFFF, 16'd2050, 1'b1, 6'd32);
    send(32'h0000_0001, 1'b1);
    expect_result("unsat", 16'd1, 16'd1, 1'b0, 6'd1);

    // Reset mid-frame discards the partial frame
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    send(32'h0000_0003, 1'b1);
    expect_result("mrst", 16'd2, 16'd1, 1'b0, 6'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
